// File: rtl/drift_pressure_tracker.sv
`default_nettype none
// ============================================================================
// Module  : drift_pressure_tracker
// Brief   : Per-channel held/handshaken drift requests with lockout, hold
//           expiry, one-deep deferral and a build/decay pressure counter.
//           Optional build macro: DRIFT_PRESSURE_FIXED_DIRECTION_EN adds a
//           fixed-direction filter (fixed_direction_en_i / fixed_direction_i).
// Rev     : 1.0  initial release
// ============================================================================

package clks_alot_p;
    localparam int DRIFT_COUNTER_WIDTH = 8;

    typedef enum logic [0:0] {
        DRIFT_LATE  = 1'b0,
        DRIFT_EARLY = 1'b1
    } drift_direction_e;
endpackage

package common_p;
    typedef struct packed {
        logic clk;
        logic rst;
    } clk_dom_s;
endpackage

module drift_pressure_tracker #(
    parameter int PRESSURE_WIDTH   = 8,
    parameter int EDGE_COUNT_WIDTH = clks_alot_p::DRIFT_COUNTER_WIDTH,
    parameter int CHANNELS         = 2
) (
    input  common_p::clk_dom_s                           sys_dom_i,
    input  logic                                         tracker_en_i,
    input  logic                                         clear_state_i,
`ifdef DRIFT_PRESSURE_FIXED_DIRECTION_EN
    input  logic                                         fixed_direction_en_i,
    input  clks_alot_p::drift_direction_e                fixed_direction_i,
`endif
    input  logic                                         drift_detected_i,
    input  clks_alot_p::drift_direction_e                drift_direction_i,
    input  logic                                         any_valid_edge_i,
    input  logic [PRESSURE_WIDTH-1:0]                    growth_rate_i,
    input  logic [PRESSURE_WIDTH-1:0]                    decay_rate_i,
    input  logic [PRESSURE_WIDTH-1:0]                    pressure_ceiling_i,
    input  logic [EDGE_COUNT_WIDTH-1:0]                  lockout_edges_i,
    input  logic [EDGE_COUNT_WIDTH-1:0]                  hold_edges_i,
    output logic [PRESSURE_WIDTH-1:0]                    pressure_o,
    output logic                                         pressure_violation_o,
    output logic                                         inverse_drift_violation_o,
    output logic [CHANNELS-1:0]                          drift_req_o,
    input  logic [CHANNELS-1:0]                          drift_res_i,
    output clks_alot_p::drift_direction_e [CHANNELS-1:0] drift_direction_o,
    output logic [CHANNELS-1:0]                          drift_expired_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_e;

    localparam logic [EDGE_COUNT_WIDTH-1:0]       c_cnt_one = 1;
    localparam clks_alot_p::drift_direction_e     c_dir_rst = clks_alot_p::drift_direction_e'(1'b0);

    logic clk;
    logic rst;
    assign clk = sys_dom_i.clk;
    assign rst = sys_dom_i.rst;

    logic w_drift_raw;
    logic w_drift;
    logic w_fixed_reject;
    logic w_edge;

    assign w_drift_raw = drift_detected_i & tracker_en_i;
    assign w_edge      = any_valid_edge_i & tracker_en_i;

`ifdef DRIFT_PRESSURE_FIXED_DIRECTION_EN
    // A rejected drift only raises the inverse pulse; it never reaches a channel or the pressure.
    assign w_fixed_reject = w_drift_raw & fixed_direction_en_i
                          & (drift_direction_i != fixed_direction_i);
`else
    assign w_fixed_reject = 1'b0;
`endif
    assign w_drift = w_drift_raw & ~w_fixed_reject;

    // ------------------------------------------------------------------
    // Pressure counter
    // ------------------------------------------------------------------
    logic [PRESSURE_WIDTH:0]   w_sum;
    logic [PRESSURE_WIDTH-1:0] w_grown;
    logic [PRESSURE_WIDTH-1:0] w_decayed;
    logic [PRESSURE_WIDTH-1:0] w_pressure_nxt;
    logic                      w_pressure_upd;

    assign w_sum     = {1'b0, pressure_o} + {1'b0, growth_rate_i};
    assign w_grown   = (w_sum > {1'b0, pressure_ceiling_i}) ? pressure_ceiling_i
                                                            : w_sum[PRESSURE_WIDTH-1:0];
    assign w_decayed = (pressure_o >= decay_rate_i) ? (pressure_o - decay_rate_i)
                                                    : '0;

    always_comb begin
        w_pressure_nxt = pressure_o;
        w_pressure_upd = 1'b0;
        if (w_drift) begin
            w_pressure_nxt = w_grown;
            w_pressure_upd = 1'b1;
        end else if (w_edge) begin
            w_pressure_nxt = w_decayed;
            w_pressure_upd = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pressure_o           <= '0;
            pressure_violation_o <= 1'b0;
        end else if (clear_state_i) begin
            pressure_o           <= '0;
            pressure_violation_o <= 1'b0;
        end else begin
            pressure_o <= w_pressure_nxt;
            if (w_pressure_upd && (w_pressure_nxt == pressure_ceiling_i)) begin
                pressure_violation_o <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Drift request channels
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0] w_inv_ch;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        state_e                          r_state;
        logic [EDGE_COUNT_WIDTH-1:0]     r_cnt;
        clks_alot_p::drift_direction_e   r_dir;
        logic                            r_slot_valid;
        clks_alot_p::drift_direction_e   r_slot_dir;
        logic                            r_req;
        logic                            r_expired;

        logic                            w_grant;
        logic [EDGE_COUNT_WIDTH-1:0]     w_cnt_inc;
        logic                            w_hold_hit;
        logic                            w_lock_done;
        logic                            w_req_opp;
        logic                            w_slot_opp;
        logic                            w_slot_valid_nxt;
        clks_alot_p::drift_direction_e   w_slot_dir_nxt;

        assign w_grant     = drift_res_i[gi] & r_req;
        assign w_cnt_inc   = r_cnt + c_cnt_one;
        assign w_hold_hit  = (hold_edges_i != '0) && (w_cnt_inc == hold_edges_i);
        assign w_lock_done = (w_cnt_inc >= lockout_edges_i);
        assign w_req_opp   = w_drift && (drift_direction_i != r_dir);
        assign w_slot_opp  = w_drift && r_slot_valid && (drift_direction_i != r_slot_dir);

        // An opposing drift annihilates the deferred entry instead of replacing it.
        always_comb begin
            w_slot_valid_nxt = r_slot_valid;
            w_slot_dir_nxt   = r_slot_dir;
            if (w_slot_opp) begin
                w_slot_valid_nxt = 1'b0;
            end else if (w_drift) begin
                w_slot_valid_nxt = 1'b1;
                w_slot_dir_nxt   = drift_direction_i;
            end
        end

        assign w_inv_ch[gi] = ((r_state == ST_PENDING) & ~w_grant & w_req_opp)
                            | ((r_state == ST_LOCKOUT) & w_slot_opp);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state      <= ST_IDLE;
                r_cnt        <= '0;
                r_dir        <= c_dir_rst;
                r_slot_valid <= 1'b0;
                r_slot_dir   <= c_dir_rst;
                r_req        <= 1'b0;
                r_expired    <= 1'b0;
            end else if (clear_state_i) begin
                r_state      <= ST_IDLE;
                r_cnt        <= '0;
                r_dir        <= c_dir_rst;
                r_slot_valid <= 1'b0;
                r_slot_dir   <= c_dir_rst;
                r_req        <= 1'b0;
                r_expired    <= 1'b0;
            end else begin
                r_expired <= 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        if (w_drift) begin
                            r_state <= ST_PENDING;
                            r_dir   <= drift_direction_i;
                            r_cnt   <= '0;
                            r_req   <= 1'b1;
                        end
                    end
                    ST_PENDING: begin
                        // A drift arriving with the grant is handled by the state we move into.
                        if (w_grant) begin
                            r_cnt <= '0;
                            if (lockout_edges_i == '0) begin
                                if (w_drift) begin
                                    r_dir <= drift_direction_i;
                                end else begin
                                    r_state <= ST_IDLE;
                                    r_req   <= 1'b0;
                                end
                            end else begin
                                r_state      <= ST_LOCKOUT;
                                r_req        <= 1'b0;
                                r_slot_valid <= w_drift;
                                r_slot_dir   <= drift_direction_i;
                            end
                        end else if (w_req_opp) begin
                            r_state <= ST_IDLE;
                            r_req   <= 1'b0;
                            r_cnt   <= '0;
                        end else if (w_edge) begin
                            if (w_hold_hit) begin
                                r_state   <= ST_IDLE;
                                r_req     <= 1'b0;
                                r_expired <= 1'b1;
                                r_cnt     <= '0;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end
                    end
                    ST_LOCKOUT: begin
                        if (w_edge && w_lock_done) begin
                            r_cnt        <= '0;
                            r_slot_valid <= 1'b0;
                            if (w_slot_valid_nxt) begin
                                r_state <= ST_PENDING;
                                r_dir   <= w_slot_dir_nxt;
                                r_req   <= 1'b1;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            if (w_edge) begin
                                r_cnt <= w_cnt_inc;
                            end
                            r_slot_valid <= w_slot_valid_nxt;
                            r_slot_dir   <= w_slot_dir_nxt;
                        end
                    end
                    default: begin
                        r_state      <= ST_IDLE;
                        r_req        <= 1'b0;
                        r_cnt        <= '0;
                        r_slot_valid <= 1'b0;
                    end
                endcase
            end
        end

        assign drift_req_o[gi]       = r_req;
        assign drift_direction_o[gi] = r_dir;
        assign drift_expired_o[gi]   = r_expired;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inverse_drift_violation_o <= 1'b0;
        end else if (clear_state_i) begin
            inverse_drift_violation_o <= 1'b0;
        end else begin
            inverse_drift_violation_o <= (|w_inv_ch) | w_fixed_reject;
        end
    end

endmodule
`default_nettype wire

// File: doc/drift_pressure_tracker.md
# drift_pressure_tracker

Parametrised successor drift-tracking block for the clock-recovery path. It converts raw drift detections into one held, handshaken drift request per channel: channel 0 drives the expected clock and channel 1 drives the preemptive clock. Drift frequency is policed with a build-and-decay saturation counter ("pressure"), and a sticky violation fires when the counter hits its ceiling. It sits between the edge/drift detector and the clock generators.

## Interface
- PRESSURE_WIDTH, 8, width of pressure counter and growth/decay/ceiling configs
- EDGE_COUNT_WIDTH, clks_alot_p::DRIFT_COUNTER_WIDTH, width of lockout/hold edge counters
- CHANNELS, 2, number of independent drift request channels (ch0 expected, ch1 preemptive)

- sys_dom_i  input  common_p::clk_dom_s  clock-domain bundle; one clock, rising edge; reset is asynchronous and active-high
- tracker_en_i  input  1  when low, drift_detected_i and any_valid_edge_i are ignored; state holds; open handshakes still complete
- clear_state_i  input  1  synchronous clear of all state to reset values (priority over everything except reset)
- drift_detected_i  input  1  single-cycle drift event
- drift_direction_i  input  clks_alot_p::drift_direction_e  direction qualifying drift_detected_i
- any_valid_edge_i  input  1  single-cycle valid-edge event
- growth_rate_i / decay_rate_i / pressure_ceiling_i  input  PRESSURE_WIDTH each  pressure add per drift / subtract per driftless edge / saturation point
- lockout_edges_i  input  EDGE_COUNT_WIDTH  valid edges after a granted drift before the channel accepts a new one
- hold_edges_i  input  EDGE_COUNT_WIDTH  valid edges a request may wait before it expires; 0 = never expire
- pressure_o  output  PRESSURE_WIDTH  current pressure
- pressure_violation_o  output  1  sticky; set when pressure reaches ceiling
- inverse_drift_violation_o  output  1  one-cycle pulse
- drift_req_o  output  CHANNELS  per-channel request, held until granted/expired
- drift_res_i  input  CHANNELS  per-channel grant
- drift_direction_o  output  CHANNELS x drift_direction_e  direction of held request
- drift_expired_o  output  CHANNELS  one-cycle pulse on request expiry

## Operation
- Per-channel FSM: IDLE, PENDING, LOCKOUT, plus a one-deep deferred slot {valid, direction}.
- Qualified drift (drift_detected_i & tracker_en_i) is broadcast to all channels:
  - IDLE: capture the direction and go to PENDING.
  - PENDING, same direction: absorbed; the hold counter is not reset.
  - PENDING, opposite direction: pulse inverse_drift_violation_o, cancel the request, go to IDLE.
  - LOCKOUT: write the deferred slot (overwrite). An opposite direction to an existing deferred entry pulses inverse violation and clears the slot.
- PENDING: drift_req_o=1. drift_res_i=1 grants; go to LOCKOUT with the edge counter = 0, or go straight to IDLE if lockout_edges_i==0. Each qualified valid edge increments the hold counter. If hold_edges_i!=0 and the count reaches hold_edges_i, pulse drift_expired_o and go to IDLE. Grant beats expiry in the same cycle.
- LOCKOUT: count qualified valid edges. On reaching lockout_edges_i, go to PENDING if the deferred slot is valid (slot consumed), else go to IDLE.
- Pressure, updated once per cycle:
  - Drift: pressure = min(pressure + growth, ceiling), computed in PRESSURE_WIDTH+1 bits.
  - Valid edge without drift: pressure = max(pressure − decay, 0).
  - Drift and edge in the same cycle: growth only.
- After an update, pressure == ceiling sets pressure_violation_o. It clears only via clear_state_i or reset. ceiling==0 means any drift sets the violation.
- Inverse pulses from several channels in the same cycle are ORed into one pulse.
- Reset / clear_state_i: FSMs go to IDLE; counters, deferred slots, pressure_o, pressure_violation_o, inverse_drift_violation_o, drift_req_o and drift_expired_o all go to 0; drift_direction_o goes to the enum's value 0. Reset mid-request drops the request without an expiry pulse.

## Timing
- All outputs are registered.
- drift_detected_i at cycle N gives drift_req_o=1 and the pressure update at N+1.
- drift_res_i sampled high with drift_req_o high at cycle N gives drift_req_o=0 at N+1.
- Deferred drift: drift_req_o rises the cycle after the final lockout edge.
- Expiry: drift_expired_o pulses and drift_req_o falls the cycle after the hold_edges_i-th edge.
- drift_direction_o is stable while drift_req_o=1.
- drift_res_i with drift_req_o=0 is ignored.

## Configuration
- DRIFT_PRESSURE_FIXED_DIRECTION_EN defined:
  - Adds ports fixed_direction_en_i (1b) and fixed_direction_i (drift_direction_e).
  - While fixed_direction_en_i=1, a drift with direction != fixed_direction_i pulses inverse_drift_violation_o and is otherwise discarded: no request, no pressure growth.
- Undefined: the ports are absent and all directions are accepted.

## Test plan
- growth=4, decay=1, ceiling=10, lockout=0, hold=0: drift at cycle 5 → req[1:0]=2'b11 at cycle 6 and pressure_o=4; grant both at cycle 8 → req=0 at cycle 9.
- Same configuration, three drifts with no edges in between → pressure 4, 8, 10; pressure_violation_o rises with the third and stays high through 5 decay edges (pressure_o 10→5) until clear_state_i.
- lockout=3: grant, then a drift after edge 1, then edges 2 and 3 → req reasserts with the deferred direction the cycle after edge 3.
- hold=2, no grant: two valid edges → drift_expired_o pulses on both channels and req drops in the same cycle.
- PENDING, then an opposite-direction drift → inverse_drift_violation_o pulses for exactly 1 cycle; req drops; pressure still grows.
- Async reset asserted mid-PENDING with pressure=7 → all outputs 0 immediately and no expiry pulse after release.
